// File: rtl/mac_rx_reader.sv
// mac_rx_reader
//   Pulls one received Ethernet frame at a time out of the RX buffer RAM and
//   streams the payload to a valid/ready sink. The first two buffer bytes carry
//   the frame length LEN, and the frame bytes sit at addresses 2..LEN. The
//   header is stripped, but the source MAC is kept on src_mac. The trailing FCS
//   is never read. Frames too short to carry any payload are dropped and
//   counted.
//
// Ports
//   Rd_Clk     in   1              sole clock
//   reset_n    in   1              asynchronous active-low reset
//   Frm_valid  in   1              buffer holds at least one complete frame
//   Rd_en      out  1              buffer read strobe
//   Rd_Addr    out  RAM_ADDR_BITS  buffer read address
//   Rd_data    in   8              buffer data, one cycle after the address
//   m_data     out  8              payload byte (FIFO head)
//   m_valid    out  1              m_data valid
//   m_last     out  1              last payload byte of the frame
//   m_ready    in   1              sink accepts the byte
//   src_mac    out  48             source MAC of the current frame
//   frm_cnt    out  16             frames delivered (saturating)
//   drop_cnt   out  16             frames rejected (saturating)
//
// State     | meaning
// ----------+----------------------------------------------------------------
// IDLE      | wait for Frm_valid
// LEN_HI    | read addr 0 (length high byte)
// LEN_LO    | read addr 1, capture length high byte
// CHECK     | capture length low byte, accept or reject the frame
// HDR       | read header addr 2..HDR_BYTES+1, shift source MAC into src_mac
// PAYLOAD   | read payload into the 2-entry FIFO under occupancy control
// DRAIN     | all addresses issued, wait for the sink to take the last byte
// RELEASE   | two idle cycles so the buffer can retire the frame

module mac_rx_reader #(
    parameter int RAM_ADDR_BITS = 14,
    parameter int HDR_BYTES     = 14,
    parameter int CRC_BYTES     = 4
) (
    input  logic                     Rd_Clk,
    input  logic                     reset_n,
    input  logic                     Frm_valid,
    output logic                     Rd_en,
    output logic [RAM_ADDR_BITS-1:0] Rd_Addr,
    input  logic [7:0]               Rd_data,
    output logic [7:0]               m_data,
    output logic                     m_valid,
    output logic                     m_last,
    input  logic                     m_ready,
    output logic [47:0]              src_mac,
    output logic [15:0]              frm_cnt,
    output logic [15:0]              drop_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        CHECK,
        HDR,
        PAYLOAD,
        DRAIN,
        RELEASE
    } state_t;

    // Smallest frame that still carries one payload byte.
    localparam logic [13:0] MIN_LEN = 14'(HDR_BYTES + CRC_BYTES + 2);
    localparam logic [RAM_ADDR_BITS-1:0] HDR_LAST  = RAM_ADDR_BITS'(HDR_BYTES + 1);
    localparam logic [RAM_ADDR_BITS-1:0] SRC_FIRST = RAM_ADDR_BITS'(8);
    localparam logic [RAM_ADDR_BITS-1:0] SRC_LAST  = RAM_ADDR_BITS'(13);
    localparam logic [RAM_ADDR_BITS-1:0] ADDR_ONE  = RAM_ADDR_BITS'(1);
    localparam logic [RAM_ADDR_BITS-1:0] ADDR_TWO  = RAM_ADDR_BITS'(2);

    state_t                     state_q, state_d;
    logic [RAM_ADDR_BITS-1:0]   addr_q, addr_d;
    logic [RAM_ADDR_BITS-1:0]   last_addr_q, last_addr_d;
    logic [RAM_ADDR_BITS-1:0]   prev_addr_q, prev_addr_d;
    logic                       prev_hdr_q, prev_hdr_d;
    logic [5:0]                 len_hi_q, len_hi_d;
    logic                       rel_cnt_q, rel_cnt_d;
    logic                       in_flight_q, in_flight_d;
    logic                       flight_last_q, flight_last_d;
    logic [1:0][7:0]            fifo_data_q, fifo_data_d;
    logic [1:0]                 fifo_last_q, fifo_last_d;
    logic                       rd_ptr_q, rd_ptr_d;
    logic                       wr_ptr_q, wr_ptr_d;
    logic [1:0]                 cnt_q, cnt_d;
    logic [47:0]                src_mac_q, src_mac_d;
    logic [15:0]                frm_cnt_q, frm_cnt_d;
    logic [15:0]                drop_cnt_q, drop_cnt_d;

    logic        push;
    logic        pop;
    logic [2:0]  occ;
    logic        issue_ok;
    logic        rd_issue;
    logic        hdr_issue;
    logic        frame_done;
    logic        frame_drop;
    logic        drained;
    logic [13:0] len_full;

    assign m_valid  = (cnt_q != 2'd0);
    assign m_data   = fifo_data_q[rd_ptr_q];
    assign m_last   = m_valid & fifo_last_q[rd_ptr_q];
    assign Rd_Addr  = addr_q;
    assign src_mac  = src_mac_q;
    assign frm_cnt  = frm_cnt_q;
    assign drop_cnt = drop_cnt_q;

    assign pop  = m_valid & m_ready;
    // A payload read issued last cycle lands in the FIFO this cycle.
    assign push = in_flight_q;

    // Occupancy the FIFO would reach if nothing new were issued; a new read is
    // allowed only if it still fits in the two entries.
    assign occ      = {1'b0, cnt_q} + {2'b00, in_flight_q} - {2'b00, pop};
    assign issue_ok = (occ < 3'd2);

    assign len_full = {len_hi_q, Rd_data};
    assign drained  = !in_flight_q && ((cnt_q == 2'd0) || ((cnt_q == 2'd1) && pop));

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        last_addr_d   = last_addr_q;
        len_hi_d      = len_hi_q;
        rel_cnt_d     = rel_cnt_q;
        flight_last_d = 1'b0;
        Rd_en         = 1'b0;
        rd_issue      = 1'b0;
        hdr_issue     = 1'b0;
        frame_done    = 1'b0;
        frame_drop    = 1'b0;

        case (state_q)
            IDLE: begin
                addr_d = '0;
                if (Frm_valid) begin
                    state_d = LEN_HI;
                end
            end
            LEN_HI: begin
                Rd_en   = 1'b1;
                addr_d  = ADDR_ONE;
                state_d = LEN_LO;
            end
            LEN_LO: begin
                Rd_en    = 1'b1;
                len_hi_d = Rd_data[5:0];
                addr_d   = ADDR_TWO;
                state_d  = CHECK;
            end
            CHECK: begin
                if (len_full >= MIN_LEN) begin
                    last_addr_d = RAM_ADDR_BITS'(len_full - 14'(CRC_BYTES));
                    state_d     = HDR;
                end else begin
                    frame_drop = 1'b1;
                    addr_d     = '0;
                    rel_cnt_d  = 1'b1;
                    state_d    = RELEASE;
                end
            end
            HDR: begin
                Rd_en     = 1'b1;
                hdr_issue = 1'b1;
                addr_d    = addr_q + ADDR_ONE;
                if (addr_q == HDR_LAST) begin
                    state_d = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (issue_ok) begin
                    Rd_en    = 1'b1;
                    rd_issue = 1'b1;
                    addr_d   = addr_q + ADDR_ONE;
                    if (addr_q == last_addr_q) begin
                        flight_last_d = 1'b1;
                        state_d       = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (drained) begin
                    frame_done = 1'b1;
                    addr_d     = '0;
                    rel_cnt_d  = 1'b1;
                    state_d    = RELEASE;
                end
            end
            RELEASE: begin
                if (rel_cnt_q == 1'b0) begin
                    state_d = IDLE;
                end else begin
                    rel_cnt_d = rel_cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        in_flight_d = rd_issue;
        prev_addr_d = addr_q;
        prev_hdr_d  = hdr_issue;

        src_mac_d = src_mac_q;
        if (prev_hdr_q && (prev_addr_q >= SRC_FIRST) && (prev_addr_q <= SRC_LAST)) begin
            src_mac_d = {src_mac_q[39:0], Rd_data};
        end

        fifo_data_d = fifo_data_q;
        fifo_last_d = fifo_last_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        if (push) begin
            fifo_data_d[wr_ptr_q] = Rd_data;
            fifo_last_d[wr_ptr_q] = flight_last_q;
            wr_ptr_d              = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};

        frm_cnt_d = frm_cnt_q;
        if (frame_done && (frm_cnt_q != 16'hFFFF)) begin
            frm_cnt_d = frm_cnt_q + 16'd1;
        end
        drop_cnt_d = drop_cnt_q;
        if (frame_drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge Rd_Clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            last_addr_q   <= '0;
            prev_addr_q   <= '0;
            prev_hdr_q    <= 1'b0;
            len_hi_q      <= '0;
            rel_cnt_q     <= 1'b0;
            in_flight_q   <= 1'b0;
            flight_last_q <= 1'b0;
            fifo_data_q   <= '0;
            fifo_last_q   <= '0;
            rd_ptr_q      <= 1'b0;
            wr_ptr_q      <= 1'b0;
            cnt_q         <= '0;
            src_mac_q     <= '0;
            frm_cnt_q     <= '0;
            drop_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            last_addr_q   <= last_addr_d;
            prev_addr_q   <= prev_addr_d;
            prev_hdr_q    <= prev_hdr_d;
            len_hi_q      <= len_hi_d;
            rel_cnt_q     <= rel_cnt_d;
            in_flight_q   <= in_flight_d;
            flight_last_q <= flight_last_d;
            fifo_data_q   <= fifo_data_d;
            fifo_last_q   <= fifo_last_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            cnt_q         <= cnt_d;
            src_mac_q     <= src_mac_d;
            frm_cnt_q     <= frm_cnt_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

endmodule
